// File: rtl/soc_addr_map_unit.sv
// soc_addr_map_unit: runtime-programmable address decoder.
// Holds NrRules rule registers (base, length, port, attributes, enable). Boot
// firmware writes them through the cfg_* port and may seal the table with a
// sticky lock. Lookups go through a 1-cycle registered valid/ready stage and
// return the matched port and attributes, or a decode error.
// Optional build macro: SOC_ADDR_MAP_ERR_LOG_EN adds a decode-error counter and
// a first-error address capture with a clear input.
module soc_addr_map_unit #(
  parameter int unsigned NrRules   = 10,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned NrPorts   = 10,
  localparam int unsigned PortW    = (NrPorts > 1) ? $clog2(NrPorts) : 1,
  localparam int unsigned IdxW     = (NrRules > 1) ? $clog2(NrRules) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  // rule programming
  input  logic                 cfg_valid_i,
  output logic                 cfg_ready_o,
  input  logic [IdxW-1:0]      cfg_idx_i,
  input  logic [AddrWidth-1:0] cfg_base_i,
  input  logic [AddrWidth-1:0] cfg_len_i,
  input  logic [PortW-1:0]     cfg_port_i,
  input  logic [1:0]           cfg_attr_i,
  input  logic                 cfg_en_i,
  input  logic                 cfg_lock_i,
  output logic                 cfg_err_o,
  output logic                 locked_o,
  // lookup request
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  // lookup response
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic [PortW-1:0]     resp_port_o,
  output logic [1:0]           resp_attr_o,
  output logic                 resp_err_o
`ifdef SOC_ADDR_MAP_ERR_LOG_EN
  ,
  input  logic                 err_clr_i,
  output logic [15:0]          err_cnt_o,
  output logic [AddrWidth-1:0] err_addr_o,
  output logic                 err_addr_valid_o
`endif
);

  typedef struct packed {
    logic                 en;
    logic [1:0]           attr;   // {exec, cached}
    logic [PortW-1:0]     port;
    logic [AddrWidth-1:0] len;
    logic [AddrWidth-1:0] base;
  } rule_t;

  rule_t rules_q [NrRules];
  logic  locked_q;
  logic  cfg_err_q;

  logic cfg_hs;
  logic idx_ok;
  logic cfg_wr;

  logic                 hit;
  logic [PortW-1:0]     hit_port;
  logic [1:0]           hit_attr;
  logic                 req_hs;

  logic                 resp_valid_q;
  logic [PortW-1:0]     resp_port_q;
  logic [1:0]           resp_attr_q;
  logic                 resp_err_q;

  // Configuration port never back-pressures; drops are reported via cfg_err_o.
  assign cfg_ready_o = 1'b1;
  assign cfg_hs      = cfg_valid_i && cfg_ready_o;
  assign idx_ok      = (32'(cfg_idx_i) < NrRules);
  assign cfg_wr      = cfg_hs && !locked_q && idx_ok;

  // Rule table write; the table is part of architectural state and must come
  // back all-disabled after reset.
  // NOTE: this register array is reset explicitly (unlike a data RAM) because
  // a stale enabled rule after reset would route traffic to the wrong target.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NrRules; i++) begin
        rules_q[i] <= '0;
      end
    end else if (cfg_wr) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, which gives the "same-cycle lookup sees the
      // old table" behaviour for free.
      rules_q[cfg_idx_i] <= '{en:   cfg_en_i,
                              attr: cfg_attr_i,
                              port: cfg_port_i,
                              len:  cfg_len_i,
                              base: cfg_base_i};
    end
  end

  // Sticky lock and one-cycle drop indication for rejected writes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      locked_q  <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_hs && !cfg_wr;
      if (cfg_wr && cfg_lock_i) begin
        locked_q <= 1'b1;
      end
    end
  end

  assign cfg_err_o = cfg_err_q;
  assign locked_o  = locked_q;

  // Priority decode: first (lowest-index) matching rule wins. The offset test
  // (addr - base) < len avoids computing base+len, so regions touching the
  // top of the address space match without wrap and len=0 never matches.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave it unassigned and infer a latch.
    hit      = 1'b0;
    hit_port = '0;
    hit_attr = '0;
    for (int unsigned i = 0; i < NrRules; i++) begin
      if (!hit && rules_q[i].en && (req_addr_i >= rules_q[i].base) &&
          ((req_addr_i - rules_q[i].base) < rules_q[i].len)) begin
        hit      = 1'b1;
        hit_port = rules_q[i].port;
        hit_attr = rules_q[i].attr;
      end
    end
  end

  // The single output stage can take a new request whenever it is empty or
  // its current result is being consumed this cycle.
  assign req_ready_o = !resp_valid_q || resp_ready_i;
  assign req_hs      = req_valid_i && req_ready_o;

  // Response register: load on accept, hold while stalled, drop valid once
  // consumed with nothing new behind it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resp_valid_q <= 1'b0;
      resp_port_q  <= '0;
      resp_attr_q  <= '0;
      resp_err_q   <= 1'b0;
    end else if (req_hs) begin
      resp_valid_q <= 1'b1;
      resp_port_q  <= hit_port;
      resp_attr_q  <= hit_attr;
      resp_err_q   <= !hit;
    end else if (resp_ready_i) begin
      resp_valid_q <= 1'b0;
    end
  end

  assign resp_valid_o = resp_valid_q;
  assign resp_port_o  = resp_port_q;
  assign resp_attr_o  = resp_attr_q;
  assign resp_err_o   = resp_err_q;

`ifdef SOC_ADDR_MAP_ERR_LOG_EN
  logic                 err_event;
  logic [15:0]          err_cnt_q;
  logic [AddrWidth-1:0] err_addr_q;
  logic                 err_addr_valid_q;

  assign err_event = req_hs && !hit;

  // Error log: saturating count of accepted error lookups plus the address of
  // the first one. A clear coinciding with an error restarts the log with it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_cnt_q        <= '0;
      err_addr_q       <= '0;
      err_addr_valid_q <= 1'b0;
    end else if (err_clr_i) begin
      err_cnt_q        <= err_event ? 16'd1 : 16'd0;
      err_addr_q       <= err_event ? req_addr_i : '0;
      err_addr_valid_q <= err_event;
    end else if (err_event) begin
      if (err_cnt_q != 16'hFFFF) begin
        err_cnt_q <= err_cnt_q + 16'd1;
      end
      if (!err_addr_valid_q) begin
        err_addr_q       <= req_addr_i;
        err_addr_valid_q <= 1'b1;
      end
    end
  end

  assign err_cnt_o        = err_cnt_q;
  assign err_addr_o       = err_addr_q;
  assign err_addr_valid_o = err_addr_valid_q;
`endif

endmodule

// File: tb/tb_soc_addr_map_unit.sv
// Testbench for soc_addr_map_unit: table-driven lookups against a response
// scoreboard, plus hand-written sequences for configuration, lock, stall,
// same-cycle write/lookup, reset and (when built with the macro) the error log.
module tb_soc_addr_map_unit;

  localparam int NrRules   = 10;
  localparam int AddrWidth = 64;
  localparam int NrPorts   = 10;
  localparam int PortW     = 4;
  localparam int IdxW      = 4;

  typedef struct packed {
    logic [PortW-1:0] port;
    logic [1:0]       attr;
    logic             err;
  } exp_t;

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    exp_t                 exp;
  } vec_t;

  logic                 clk_i = 1'b0;
  logic                 rst_ni;
  logic                 cfg_valid_i;
  logic                 cfg_ready_o;
  logic [IdxW-1:0]      cfg_idx_i;
  logic [AddrWidth-1:0] cfg_base_i;
  logic [AddrWidth-1:0] cfg_len_i;
  logic [PortW-1:0]     cfg_port_i;
  logic [1:0]           cfg_attr_i;
  logic                 cfg_en_i;
  logic                 cfg_lock_i;
  logic                 cfg_err_o;
  logic                 locked_o;
  logic                 req_valid_i;
  logic                 req_ready_o;
  logic [AddrWidth-1:0] req_addr_i;
  logic                 resp_valid_o;
  logic                 resp_ready_i;
  logic [PortW-1:0]     resp_port_o;
  logic [1:0]           resp_attr_o;
  logic                 resp_err_o;
`ifdef SOC_ADDR_MAP_ERR_LOG_EN
  logic                 err_clr_i;
  logic [15:0]          err_cnt_o;
  logic [AddrWidth-1:0] err_addr_o;
  logic                 err_addr_valid_o;
`endif

  soc_addr_map_unit #(
    .NrRules  (NrRules),
    .AddrWidth(AddrWidth),
    .NrPorts  (NrPorts)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .cfg_valid_i (cfg_valid_i),
    .cfg_ready_o (cfg_ready_o),
    .cfg_idx_i   (cfg_idx_i),
    .cfg_base_i  (cfg_base_i),
    .cfg_len_i   (cfg_len_i),
    .cfg_port_i  (cfg_port_i),
    .cfg_attr_i  (cfg_attr_i),
    .cfg_en_i    (cfg_en_i),
    .cfg_lock_i  (cfg_lock_i),
    .cfg_err_o   (cfg_err_o),
    .locked_o    (locked_o),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr_i),
    .resp_valid_o(resp_valid_o),
    .resp_ready_i(resp_ready_i),
    .resp_port_o (resp_port_o),
    .resp_attr_o (resp_attr_o),
    .resp_err_o  (resp_err_o)
`ifdef SOC_ADDR_MAP_ERR_LOG_EN
    ,
    .err_clr_i       (err_clr_i),
    .err_cnt_o       (err_cnt_o),
    .err_addr_o      (err_addr_o),
    .err_addr_valid_o(err_addr_valid_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_pushed = 0;
  int   n_popped = 0;
  exp_t sb [$];
  exp_t mon_e;
  vec_t vecs [14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every consumed response is compared against the oldest expectation.
  always @(negedge clk_i) begin
    if (rst_ni && resp_valid_o && resp_ready_i) begin
      if (sb.size() == 0) begin
        check("resp_unexpected", 64'(resp_valid_o), 64'(0));
      end else begin
        mon_e = sb.pop_front();
        n_popped++;
        check("resp", 64'({resp_port_o, resp_attr_o, resp_err_o}), 64'(mon_e));
      end
    end
  end

  // Drive one lookup; called at posedge+1, returns at posedge+1 after accept.
  task automatic send(input logic [63:0] addr, input logic [PortW-1:0] port,
                      input logic [1:0] attr, input logic err);
    int budget = 0;
    req_valid_i = 1'b1;
    req_addr_i  = addr;
    @(negedge clk_i);
    while (!req_ready_o && budget < 50) begin
      budget++;
      @(negedge clk_i);
    end
    if (!req_ready_o) begin
      check("req_ready_timeout", 64'(req_ready_o), 64'(1));
      req_valid_i = 1'b0;
      return;
    end
    sb.push_back('{port, attr, err});
    n_pushed++;
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
  endtask

  // Drive one configuration write; called and returns at posedge+1.
  task automatic cfg_write(input logic [IdxW-1:0] idx, input logic [63:0] base,
                           input logic [63:0] len, input logic [PortW-1:0] port,
                           input logic [1:0] attr, input logic en, input logic lock);
    cfg_idx_i   = idx;
    cfg_base_i  = base;
    cfg_len_i   = len;
    cfg_port_i  = port;
    cfg_attr_i  = attr;
    cfg_en_i    = en;
    cfg_lock_i  = lock;
    cfg_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    cfg_valid_i = 1'b0;
    cfg_lock_i  = 1'b0;
  endtask

  task automatic drain();
    int budget = 0;
    while (sb.size() != 0 && budget < 50) begin
      budget++;
      @(posedge clk_i);
      #1;
    end
    check("drain", 64'(sb.size()), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{64'h0000_0000_8000_0000, '{4'd0, 2'd3, 1'b0}};
    vecs[1]  = '{64'h0000_0000_BFFF_FFFF, '{4'd0, 2'd3, 1'b0}};
    vecs[2]  = '{64'h0000_0000_C000_0000, '{4'd0, 2'd0, 1'b1}};
    vecs[3]  = '{64'h0000_0000_7FFF_FFFF, '{4'd0, 2'd0, 1'b1}};
    vecs[4]  = '{64'h0000_0000_1000_0800, '{4'd5, 2'd1, 1'b0}};
    vecs[5]  = '{64'h0000_0000_1000_0FFF, '{4'd5, 2'd1, 1'b0}};
    vecs[6]  = '{64'h0000_0000_1000_1000, '{4'd2, 2'd2, 1'b0}};
    vecs[7]  = '{64'h0000_0000_1000_2000, '{4'd2, 2'd2, 1'b0}};
    vecs[8]  = '{64'h0000_0000_1001_0000, '{4'd0, 2'd0, 1'b1}};
    vecs[9]  = '{64'hFFFF_FFFF_FFFF_FFFF, '{4'd8, 2'd1, 1'b0}};
    vecs[10] = '{64'hFFFF_FFFF_FFFF_F000, '{4'd8, 2'd1, 1'b0}};
    vecs[11] = '{64'hFFFF_FFFF_FFFF_EFFF, '{4'd0, 2'd0, 1'b1}};
    vecs[12] = '{64'h0000_0000_4000_0000, '{4'd0, 2'd0, 1'b1}};
    vecs[13] = '{64'h0000_0000_6000_0000, '{4'd0, 2'd0, 1'b1}};

    rst_ni       = 1'b0;
    cfg_valid_i  = 1'b0;
    cfg_idx_i    = '0;
    cfg_base_i   = '0;
    cfg_len_i    = '0;
    cfg_port_i   = '0;
    cfg_attr_i   = '0;
    cfg_en_i     = 1'b0;
    cfg_lock_i   = 1'b0;
    req_valid_i  = 1'b0;
    req_addr_i   = '0;
    resp_ready_i = 1'b1;
`ifdef SOC_ADDR_MAP_ERR_LOG_EN
    err_clr_i    = 1'b0;
`endif
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_resp_valid", 64'(resp_valid_o), 64'(0));
    check("rst_resp_fields", 64'({resp_port_o, resp_attr_o, resp_err_o}), 64'(0));
    check("rst_locked", 64'(locked_o), 64'(0));
    check("rst_cfg_err", 64'(cfg_err_o), 64'(0));
    check("rst_cfg_ready", 64'(cfg_ready_o), 64'(1));
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Empty table: first lookup errors, result visible one cycle after accept.
    send(64'h8000_0000, 4'd0, 2'd0, 1'b1);
    check("latency_valid", 64'(resp_valid_o), 64'(1));
    drain();

    // Program the table.
    cfg_write(4'd0, 64'h8000_0000, 64'h4000_0000, 4'd0, 2'b11, 1'b1, 1'b0);
    cfg_write(4'd1, 64'h1000_0000, 64'h1000, 4'd5, 2'b01, 1'b1, 1'b0);
    cfg_write(4'd4, 64'h1000_0000, 64'h1_0000, 4'd2, 2'b10, 1'b1, 1'b0);
    cfg_write(4'd5, 64'hFFFF_FFFF_FFFF_F000, 64'h1000, 4'd8, 2'b01, 1'b1, 1'b0);
    cfg_write(4'd6, 64'h4000_0000, 64'h0, 4'd6, 2'b11, 1'b1, 1'b0);
    cfg_write(4'd7, 64'h6000_0000, 64'h1000, 4'd9, 2'b11, 1'b0, 1'b0);
    check("cfg_err_good_write", 64'(cfg_err_o), 64'(0));

    // Table-driven lookups, issued back to back.
    for (int i = 0; i < 14; i++) begin
      send(vecs[i].addr, vecs[i].exp.port, vecs[i].exp.attr, vecs[i].exp.err);
    end
    drain();

    // Out-of-range index is dropped with a one-cycle error pulse.
    cfg_write(4'd12, 64'h0, 64'h1_0000_0000, 4'd1, 2'b00, 1'b1, 1'b0);
    check("cfg_err_bad_idx", 64'(cfg_err_o), 64'(1));
    @(posedge clk_i);
    #1;
    check("cfg_err_pulse_end", 64'(cfg_err_o), 64'(0));
    check("locked_before", 64'(locked_o), 64'(0));

    // Write and lookup in the same cycle: lookup sees the old table.
    cfg_idx_i   = 4'd2;
    cfg_base_i  = 64'h3000_0000;
    cfg_len_i   = 64'h1000;
    cfg_port_i  = 4'd3;
    cfg_attr_i  = 2'b10;
    cfg_en_i    = 1'b1;
    cfg_lock_i  = 1'b0;
    cfg_valid_i = 1'b1;
    send(64'h3000_0000, 4'd0, 2'd0, 1'b1);
    cfg_valid_i = 1'b0;
    send(64'h3000_0000, 4'd3, 2'd2, 1'b0);
    drain();

    // Lock with a write, then a later write to rule0 is dropped.
    cfg_write(4'd3, 64'h2000_0000, 64'h100, 4'd7, 2'b01, 1'b1, 1'b1);
    check("locked_set", 64'(locked_o), 64'(1));
    check("cfg_err_lock_write", 64'(cfg_err_o), 64'(0));
    cfg_write(4'd0, 64'h8000_0000, 64'h10, 4'd9, 2'b00, 1'b1, 1'b0);
    check("cfg_err_locked", 64'(cfg_err_o), 64'(1));
    @(posedge clk_i);
    #1;
    check("cfg_err_locked_end", 64'(cfg_err_o), 64'(0));
    check("locked_sticky", 64'(locked_o), 64'(1));
    send(64'h8000_0000, 4'd0, 2'd3, 1'b0);
    send(64'h2000_0010, 4'd7, 2'd1, 1'b0);
    send(64'h8000_0020, 4'd0, 2'd3, 1'b0);
    drain();

    // Back-pressure: hold resp_ready low for three cycles.
    @(posedge clk_i);
    #1;
    resp_ready_i = 1'b0;
    send(64'h1000_0800, 4'd5, 2'd1, 1'b0);
    fork
      begin
        send(64'h1000_2000, 4'd2, 2'd2, 1'b0);
        send(64'hC000_0000, 4'd0, 2'd0, 1'b1);
        send(64'h2000_0000, 4'd7, 2'd1, 1'b0);
      end
      begin
        for (int k = 0; k < 3; k++) begin
          @(negedge clk_i);
          check("stall_req_ready", 64'(req_ready_o), 64'(0));
          check("stall_resp_valid", 64'(resp_valid_o), 64'(1));
          check("stall_resp_hold", 64'({resp_port_o, resp_attr_o, resp_err_o}),
                64'({4'd5, 2'd1, 1'b0}));
        end
        @(posedge clk_i);
        #1;
        resp_ready_i = 1'b1;
      end
    join
    drain();
    check("no_loss_no_dup", 64'(n_popped), 64'(n_pushed));

    // Reset with a response in flight: it is discarded and the table cleared.
    resp_ready_i = 1'b0;
    send(64'h8000_0000, 4'd0, 2'd3, 1'b0);
    rst_ni = 1'b0;
    sb.delete();
    n_pushed--;
    #1;
    check("midrst_resp_valid", 64'(resp_valid_o), 64'(0));
    check("midrst_locked", 64'(locked_o), 64'(0));
    @(posedge clk_i);
    #1;
    rst_ni       = 1'b1;
    resp_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    send(64'h8000_0000, 4'd0, 2'd0, 1'b1);
    drain();

`ifdef SOC_ADDR_MAP_ERR_LOG_EN
    err_clr_i = 1'b1;
    @(posedge clk_i);
    #1;
    err_clr_i = 1'b0;
    check("errlog_clr_cnt", 64'(err_cnt_o), 64'(0));
    check("errlog_clr_valid", 64'(err_addr_valid_o), 64'(0));
    send(64'h5000_0000, 4'd0, 2'd0, 1'b1);
    send(64'h6000_0000, 4'd0, 2'd0, 1'b1);
    send(64'h7000_0000, 4'd0, 2'd0, 1'b1);
    check("errlog_cnt3", 64'(err_cnt_o), 64'(3));
    check("errlog_addr_first", err_addr_o, 64'h5000_0000);
    check("errlog_addr_valid", 64'(err_addr_valid_o), 64'(1));
    err_clr_i = 1'b1;
    send(64'h7800_0000, 4'd0, 2'd0, 1'b1);
    err_clr_i = 1'b0;
    check("errlog_clr_err_cnt", 64'(err_cnt_o), 64'(1));
    check("errlog_clr_err_addr", err_addr_o, 64'h7800_0000);
    check("errlog_clr_err_valid", 64'(err_addr_valid_o), 64'(1));
    drain();
`endif

    check("final_balance", 64'(n_popped), 64'(n_pushed));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
